// File: rtl/hs_pkg.sv
// Shared types and constants for the toggle-handshake transmitter.
// The ack synchronizer depth is fixed here because the majority vote assumes exactly three taps.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } hs_state_t;

    localparam int HS_SYNC_DEPTH = 3;

    // Two-of-three vote; a value held by only one tap can never win.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/hs_ack_sync.sv
// Majority-vote synchronizer for the asynchronous acknowledge toggle.
// A single-cycle glitch only ever occupies one tap, so it never reaches ack_s.
module hs_ack_sync
    import hs_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic nrst,
    input  logic in_ack,
    output logic ack_s
);

    logic [HS_SYNC_DEPTH-1:0] sync_d;
    logic [HS_SYNC_DEPTH-1:0] sync_q;

    // Shift the raw ack into the tap chain.
    always_comb begin
        sync_d = {sync_q[HS_SYNC_DEPTH-2:0], in_ack};
    end

    // Tap chain register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= {HS_SYNC_DEPTH{RESET_VALUE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ack_s = maj3(sync_q);

endmodule

// File: rtl/hs_tx.sv
// Sending end of a toggle-handshake link: holds out_data for MIN_HOLD cycles,
// toggles out_req, then waits for the synchronized ack to match before accepting again.
module hs_tx
    import hs_pkg::*;
#(
    parameter int              SIZE        = 8,
    parameter logic [SIZE-1:0] RESET_VALUE = {SIZE{1'b0}},
    parameter int              MIN_HOLD    = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic [SIZE-1:0] out_data,
    output logic            out_req,
    input  logic            in_ack,
    output logic            busy,
    output logic            err
);

    localparam int               CNT_W    = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    if (MIN_HOLD < 1) begin : g_min_hold_chk
        $error("hs_tx: MIN_HOLD must be at least 1");
    end

    hs_state_t        state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [SIZE-1:0]  out_data_d, out_data_q;
    logic             out_req_d, out_req_q;
    logic             err_d, err_q;
    logic             ack_p_d, ack_p_q;
    logic             ack_s;

    hs_ack_sync #(
        .RESET_VALUE(1'b0)
    ) u_ack_sync (
        .clk   (clk),
        .nrst  (nrst),
        .in_ack(in_ack),
        .ack_s (ack_s)
    );

    // Transfer sequencing: accept, hold data, toggle request, wait for matching ack.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_req_d  = out_req_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    out_data_d = in_data;
                    cnt_d      = CNT_LOAD;
                    state_d    = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    out_req_d = ~out_req_q;
                    state_d   = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_ACK: begin
                if (ack_s == out_req_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Any ack edge outside WAIT_ACK is unsolicited; the flag is sticky until reset.
    always_comb begin
        ack_p_d = ack_s;
        err_d   = err_q | ((ack_s != ack_p_q) && (state_q != WAIT_ACK));
    end

    // State, data and flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            out_data_q <= RESET_VALUE;
            out_req_q  <= 1'b0;
            err_q      <= 1'b0;
            ack_p_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_req_q  <= out_req_d;
            err_q      <= err_d;
            ack_p_q    <= ack_p_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign out_data = out_data_q;
    assign out_req  = out_req_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hs_tx.sv
// Bench for hs_tx: directed handshake scenarios plus randomized traffic against a
// timestamp-based reference model; a second instance covers MIN_HOLD=1.
module tb_hs_tx;

    localparam int MH = 4;

    logic       clk;
    logic       nrst;
    logic       in_valid, in_ready, in_ack, out_req, busy, err;
    logic [7:0] in_data, out_data;
    logic       in_valid1, in_ready1, in_ack1, out_req1, busy1, err1;
    logic [7:0] in_data1, out_data1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (transaction timestamps, not FSM encoding)
    bit       m_busy, m_req, m_err, m_ackp;
    bit [7:0] m_data;
    int       hist[3];
    int       n_edge, m_acc;
    bit       far_ack;
    int       dly;

    hs_tx #(.SIZE(8), .RESET_VALUE(8'h00), .MIN_HOLD(MH)) u_dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_data(out_data), .out_req(out_req),
        .in_ack(in_ack), .busy(busy), .err(err)
    );

    hs_tx #(.SIZE(8), .RESET_VALUE(8'h00), .MIN_HOLD(1)) u_dut1 (
        .clk(clk), .nrst(nrst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_data(out_data1), .out_req(out_req1),
        .in_ack(in_ack1), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_req = 1'b0; m_err = 1'b0; m_ackp = 1'b0;
        m_data = 8'h00; hist = '{0, 0, 0}; n_edge = 0; m_acc = 0;
    endtask

    // One clock edge of the reference: the far side's view of ack is the 2-of-3 vote
    // over the last three sampled in_ack values.
    task automatic model_step();
        bit vis, waiting;
        vis     = (hist[0] + hist[1] + hist[2]) >= 2;
        waiting = m_busy && (n_edge > m_acc + MH);
        if ((vis != m_ackp) && !waiting) m_err = 1'b1;
        if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1; m_acc = n_edge; m_data = in_data;
            end
        end else if (n_edge == m_acc + MH) begin
            m_req = ~m_req;
        end else if (waiting && (vis == m_req)) begin
            m_busy = 1'b0;
        end
        m_ackp  = vis;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(in_ack);
        n_edge++;
    endtask

    task automatic compare_all();
        check_eq("m_ready", 32'(in_ready), 32'(!m_busy));
        check_eq("m_busy",  32'(busy),     32'(m_busy));
        check_eq("m_req",   32'(out_req),  32'(m_req));
        check_eq("m_data",  32'(out_data), 32'(m_data));
        check_eq("m_err",   32'(err),      32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        if (nrst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        nrst = 1'b0; in_valid = 1'b0; in_ack = 1'b0; in_ack1 = 1'b0; in_valid1 = 1'b0;
        far_ack = 1'b0;
        model_reset();
        #1;
        check_eq("rst_req",   32'(out_req),  32'h0);
        check_eq("rst_data",  32'(out_data), 32'h0);
        check_eq("rst_ready", 32'(in_ready), 32'h1);
        check_eq("rst_busy",  32'(busy),     32'h0);
        check_eq("rst_err",   32'(err),      32'h0);
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic wait_req(input logic v, input string tag);
        int i = 0;
        while (out_req !== v && i < 40) begin tick(); i++; end
        check_eq(tag, 32'(out_req), 32'(v));
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy !== 1'b0 && i < 40) begin tick(); i++; end
        check_eq(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        nrst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_ack = 1'b0;
        in_valid1 = 1'b0; in_data1 = 8'h00; in_ack1 = 1'b0;
        do_reset();

        // Single transfer
        in_valid = 1'b1; in_data = 8'hA5; tick();
        in_valid = 1'b0;
        check_eq("st_data", 32'(out_data), 32'hA5);
        check_eq("st_busy", 32'(busy), 32'h1);
        check_eq("st_ready", 32'(in_ready), 32'h0);
        tick(); tick(); tick();
        check_eq("st_req_k3", 32'(out_req), 32'h0);
        tick();
        check_eq("st_req_k4", 32'(out_req), 32'h1);
        repeat (4) tick();
        in_ack = 1'b1;
        tick(); tick();
        check_eq("st_busy_a1", 32'(busy), 32'h1);
        tick();
        check_eq("st_busy_a2", 32'(busy), 32'h0);
        check_eq("st_ready_a2", 32'(in_ready), 32'h1);
        check_eq("st_err", 32'(err), 32'h0);

        // MIN_HOLD=1 instance
        in_valid1 = 1'b1; in_data1 = 8'h5A; tick();
        in_valid1 = 1'b0;
        check_eq("mh1_data", 32'(out_data1), 32'h5A);
        check_eq("mh1_req_k", 32'(out_req1), 32'h0);
        check_eq("mh1_busy", 32'(busy1), 32'h1);
        tick();
        check_eq("mh1_req_k1", 32'(out_req1), 32'h1);
        in_ack1 = 1'b1;
        for (int i = 0; i < 20 && busy1 !== 1'b0; i++) tick();
        check_eq("mh1_done", 32'(busy1), 32'h0);
        check_eq("mh1_err", 32'(err1), 32'h0);

        // Back-to-back
        do_reset();
        in_valid = 1'b1; in_data = 8'h01; tick();
        check_eq("bb_data1", 32'(out_data), 32'h01);
        in_data = 8'h02;
        repeat (4) tick();
        check_eq("bb_req1", 32'(out_req), 32'h1);
        check_eq("bb_hold1", 32'(out_data), 32'h01);
        in_ack = 1'b1;
        tick(); tick();
        check_eq("bb_noacc", 32'(in_ready), 32'h0);
        check_eq("bb_hold2", 32'(out_data), 32'h01);
        tick();
        check_eq("bb_ready", 32'(in_ready), 32'h1);
        check_eq("bb_hold3", 32'(out_data), 32'h01);
        tick();
        check_eq("bb_data2", 32'(out_data), 32'h02);
        in_valid = 1'b0;
        repeat (4) tick();
        check_eq("bb_req2", 32'(out_req), 32'h0);
        in_ack = 1'b0;
        wait_idle("bb_done");

        // Ack glitch during WAIT_ACK
        in_valid = 1'b1; in_data = 8'($urandom); tick();
        in_valid = 1'b0;
        wait_req(1'b1, "gl_req");
        tick();
        in_ack = 1'b1; tick(); in_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); check_eq("gl_busy", 32'(busy), 32'h1); end
        check_eq("gl_err0", 32'(err), 32'h0);
        in_ack = 1'b1;
        wait_idle("gl_done");
        check_eq("gl_err1", 32'(err), 32'h0);

        // Spurious ack in IDLE, err sticky through a clean transfer
        in_ack = 1'b0; repeat (4) tick();
        in_ack = 1'b1; repeat (4) tick();
        check_eq("sp_err", 32'(err), 32'h1);
        in_valid = 1'b1; in_data = 8'h77; tick();
        in_valid = 1'b0;
        wait_req(1'b0, "sp_req");
        in_ack = 1'b0;
        wait_idle("sp_done");
        check_eq("sp_err_sticky", 32'(err), 32'h1);

        // Reset mid-transfer, then a clean transfer
        in_valid = 1'b1; in_data = 8'hC3; tick();
        in_valid = 1'b0;
        repeat (MH + 1) tick();
        check_eq("mr_busy", 32'(busy), 32'h1);
        do_reset();
        in_valid = 1'b1; in_data = 8'h3C; tick();
        in_valid = 1'b0;
        wait_req(1'b1, "mr_req");
        in_ack = 1'b1;
        wait_idle("mr_done");
        check_eq("mr_data", 32'(out_data), 32'h3C);
        check_eq("mr_err", 32'(err), 32'h0);

        // Randomized traffic with a lagging, occasionally glitchy far side
        for (int r = 0; r < 4; r++) begin
            do_reset();
            dly = 0;
            for (int c = 0; c < 600; c++) begin
                in_valid = ($urandom_range(0, 9) < 6);
                in_data  = 8'($urandom);
                if (far_ack != m_req) begin
                    if (dly == 0) far_ack = m_req;
                    else dly--;
                end else begin
                    dly = $urandom_range(0, 6);
                end
                if (r > 1 && $urandom_range(0, 299) == 0) far_ack = ~far_ack;
                in_ack = far_ack ^ ($urandom_range(0, 19) == 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hs_tx.md
# hs_tx

Four-phase-free (toggle) handshake transmitter that sends a SIZE-bit word to a block in another clock domain. The far side samples `out_data`/`out_req` through a 3-flop majority-vote synchronizer and returns `in_ack`. This block is the sending end of that link. It guarantees that `out_data` is stable for MIN_HOLD cycles before `out_req` toggles, and that it stays stable until the acknowledge has come back. Upstream logic (config/SPI side) pushes words with a valid/ready handshake.

## Interface
- `SIZE`, 8, width of the transferred word.
- `RESET_VALUE`, 0, reset value of `out_data`.
- `MIN_HOLD`, 4, number of cycles `out_data` is stable before the `out_req` toggle. Must be ≥1; elaboration-time assertion.
- `clk` input 1: single clock.
- `nrst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can accept a word.
- `in_data` input SIZE: upstream word.
- `out_data` output SIZE: word presented to the far domain. Registered.
- `out_req` output 1: request toggle. Registered.
- `in_ack` input 1: acknowledge toggle from the far domain. Asynchronous.
- `busy` output 1: a transfer is in flight.
- `err` output 1: sticky protocol error flag.

## Operation
- Ack path: `in_ack` passes through a 3-flop chain (reset 0). `ack_s` is the majority of the 3 flops. A registered copy `ack_p` holds the previous `ack_s`.
- The FSM has three states: IDLE, SETUP and WAIT_ACK. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `out_data`<=`in_data`, `cnt`<=MIN_HOLD-1, go to SETUP.
- SETUP:
  - If `cnt`==0: `out_req`<=~`out_req`, go to WAIT_ACK.
  - Otherwise: `cnt`<=`cnt`-1.
- WAIT_ACK:
  - When `ack_s`==`out_req`, go to IDLE.
- Combinational outputs: `in_ready` = (state==IDLE); `busy` = (state!=IDLE).
- `out_data` changes only on an accept. It holds the last word indefinitely in IDLE.
- `err` is set when `ack_s`!=`ack_p` while state!=WAIT_ACK, i.e. an unsolicited ack edge. It is cleared only by `nrst`. `err` does not alter FSM behaviour.
- `cnt` width is $clog2(MIN_HOLD) with a minimum of 1.
- Reset values: `out_data`=RESET_VALUE, `out_req`=0, `err`=0, `in_ready`=1, `busy`=0, ack flops=0.
- Reset mid-transfer aborts the transfer immediately. The far side must be reset together with this block; the link has no resynchronization.
- An ack toggle that arrives during SETUP sets `err`. The FSM still waits in WAIT_ACK for `ack_s`==`out_req`, so a stale ack matching the new `out_req` completes the transfer.

## Timing
- Accept happens at the edge where `in_valid`&`in_ready` are sampled high (edge k). `out_data` updates at edge k.
- `out_req` toggles at edge k+MIN_HOLD.
- Ack latency: an `in_ack` change that is stable from edge a is visible in `ack_s` after edge a+1. Majority vote needs 2 of 3 flops, so it is effectively 2 edges.
- FSM returns to IDLE at the edge after `ack_s` matches. `in_ready` is high in the following cycle, so the next accept is one cycle later at the earliest.
- A single-cycle `in_ack` glitch never reaches `ack_s`, because only one flop holds it at a time.
- Minimum transfer period is MIN_HOLD + 1 (accept→SETUP) + ack round trip + 1.

## Structure
- Package `hs_pkg`:
  - state enum `hs_state_t` {IDLE, SETUP, WAIT_ACK}
  - sync depth constant `HS_SYNC_DEPTH`=3
- Sub-module `hs_ack_sync`:
  - 3-flop majority-vote synchronizer on `in_ack`, parameterized by reset value.
  - Provides `ack_s`; the top registers `ack_p`.
- Top holds the FSM, `cnt`, data/req registers and `err`.

## Test plan
- **Single transfer.** SIZE=8, MIN_HOLD=4, `in_data`=0xA5, `in_valid` for one cycle, then `in_ack`=1 five cycles after the `out_req` rise.
  - `out_data`=0xA5 from edge k.
  - `out_req` 0→1 at edge k+4.
  - `busy` is high from k until 3 edges after the `in_ack` rise; then `in_ready`=1 and `err`=0.
- **Back-to-back.** `in_valid` held with 0x01 then 0x02.
  - 0x02 is not accepted until the first ack returns.
  - `out_data` stays 0x01 throughout the first transfer.
  - `out_req` goes 1 then 0 on the second transfer.
- **Ack glitch.** In WAIT_ACK, a 1-cycle `in_ack` pulse → no state change and `busy` stays 1. A later ≥2-cycle-stable ack completes the transfer.
- **Spurious ack.** Toggle `in_ack` for 4 cycles while in IDLE → `err`=1, which stays set through subsequent normal transfers until `nrst`.
- **Reset mid-transfer.** Assert `nrst`=0 in WAIT_ACK → outputs are asynchronously at their reset values (`out_req`=0, `out_data`=RESET_VALUE, `in_ready`=1). After release, a new transfer completes normally.
- **MIN_HOLD=1.** Accept at edge k → `out_req` toggles at k+1.
